// File: rtl/voice_allocator_if.sv
// Key-event and shared-divider signals between the voice allocator and its neighbours.
// master: key decoder / divider side, slave: voice allocator side.
interface voice_allocator_if;
  logic        ev_valid;
  logic        ev_ready;
  logic [7:0]  ev_code;
  logic        ev_pressed;
  logic        div_start;
  logic [31:0] div_num;
  logic [31:0] div_den;
  logic        div_done;
  logic [31:0] div_quot;

  modport master (
    output ev_valid, ev_code, ev_pressed, div_done, div_quot,
    input  ev_ready, div_start, div_num, div_den
  );

  modport slave (
    input  ev_valid, ev_code, ev_pressed, div_done, div_quot,
    output ev_ready, div_start, div_num, div_den
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps PS/2 key events to just-intonation notes, allocates voice
// slots (LRU stealing when full) and sequences a shared divider to compute each voice frequency.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned FREQ_W     = 32,
  parameter int unsigned BASE_FREQ  = 110,
  parameter int unsigned FRAC       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  voice_allocator_if.slave             bus,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES-1:0]        voice_start,
  output logic [NUM_VOICES*4-1:0]      voice_note,
  output logic [NUM_VOICES*FREQ_W-1:0] voice_freq
);

  localparam int unsigned VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [2:0] {
    StIdle, StDecode, StDivReq, StDivWait, StWrite, StRelease
  } state_e;

  // Returns {valid, note}; unknown codes come back with valid=0.
  function automatic logic [4:0] code_to_note(input logic [7:0] code);
    unique case (code)
      8'h15:   return {1'b1, 4'd0};
      8'h16:   return {1'b1, 4'd1};
      8'h1D:   return {1'b1, 4'd2};
      8'h26:   return {1'b1, 4'd3};
      8'h24:   return {1'b1, 4'd4};
      8'h2D:   return {1'b1, 4'd5};
      8'h2E:   return {1'b1, 4'd6};
      8'h2C:   return {1'b1, 4'd7};
      8'h36:   return {1'b1, 4'd8};
      8'h35:   return {1'b1, 4'd9};
      8'h3D:   return {1'b1, 4'd10};
      8'h3C:   return {1'b1, 4'd11};
      8'h43:   return {1'b1, 4'd12};
      default: return 5'd0;
    endcase
  endfunction

  // Just-intonation ratio {numerator, denominator} for notes 0..12.
  function automatic logic [11:0] note_ratio(input logic [3:0] note);
    unique case (note)
      4'd0:    return {6'd1,  6'd1};
      4'd1:    return {6'd16, 6'd15};
      4'd2:    return {6'd9,  6'd8};
      4'd3:    return {6'd6,  6'd5};
      4'd4:    return {6'd5,  6'd4};
      4'd5:    return {6'd4,  6'd3};
      4'd6:    return {6'd45, 6'd32};
      4'd7:    return {6'd3,  6'd2};
      4'd8:    return {6'd8,  6'd5};
      4'd9:    return {6'd5,  6'd3};
      4'd10:   return {6'd16, 6'd9};
      4'd11:   return {6'd15, 6'd8};
      default: return {6'd2,  6'd1};
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [7:0]          code_q;
  logic                pressed_q;
  logic [VW-1:0]       target_q;
  logic                retrig_q;
  logic [31:0]         div_num_q, div_den_q, quot_q;
  logic                active_q [NUM_VOICES];
  logic                start_q  [NUM_VOICES];
  logic [3:0]          note_q   [NUM_VOICES];
  logic [FREQ_W-1:0]   freq_q   [NUM_VOICES];
  logic [VW-1:0]       rank_q   [NUM_VOICES];

  logic                dec_valid;
  logic [3:0]          dec_note;
  logic [11:0]         ratio;
  logic                hit, free;
  logic [VW-1:0]       hit_slot, free_slot, lru_slot;
  logic [FREQ_W-1:0]   freq_val;

  // Decode the captured event and find candidate slots (active match, lowest free, oldest).
  always_comb begin
    {dec_valid, dec_note} = code_to_note(code_q);
    ratio     = note_ratio(dec_note);
    hit       = 1'b0;
    hit_slot  = '0;
    free      = 1'b0;
    free_slot = '0;
    lru_slot  = '0;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free      = 1'b1;
        free_slot = VW'(i);
      end
      if (active_q[i] && note_q[i] == dec_note) begin
        hit      = 1'b1;
        hit_slot = VW'(i);
      end
      if (rank_q[i] == VW'(NUM_VOICES - 1)) lru_slot = VW'(i);
    end
    freq_val = FREQ_W'(64'(quot_q) * 64'(BASE_FREQ));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.ev_valid) state_d = StDecode;
      StDecode: begin
        if (!dec_valid)      state_d = StIdle;
        else if (!pressed_q) state_d = StRelease;
        else if (hit)        state_d = StWrite;
        else                 state_d = StDivReq;
      end
      StDivReq:  state_d = StDivWait;
      StDivWait: if (bus.div_done) state_d = StWrite;
      StWrite:   state_d = StIdle;
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.ev_ready  = (state_q == StIdle);
    bus.div_start = (state_q == StDivReq);
  end

  // Event capture, slot selection, divider operands and voice state updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      code_q    <= '0;
      pressed_q <= 1'b0;
      target_q  <= '0;
      retrig_q  <= 1'b0;
      div_num_q <= '0;
      div_den_q <= '0;
      quot_q    <= '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        active_q[i] <= 1'b0;
        start_q[i]  <= 1'b0;
        note_q[i]   <= '0;
        freq_q[i]   <= '0;
        rank_q[i]   <= VW'(i);
      end
    end else begin
      for (int i = 0; i < int'(NUM_VOICES); i++) start_q[i] <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.ev_valid) begin
            code_q    <= bus.ev_code;
            pressed_q <= bus.ev_pressed;
          end
        end
        StDecode: begin
          if (dec_valid && pressed_q) begin
            retrig_q <= hit;
            if (hit)       target_q <= hit_slot;
            else if (free) target_q <= free_slot;
            else           target_q <= lru_slot;
            if (!hit) begin
              div_num_q <= 32'(ratio[11:6]) << FRAC;
              div_den_q <= 32'(ratio[5:0]);
            end
          end
        end
        StDivWait: if (bus.div_done) quot_q <= bus.div_quot;
        StWrite: begin
          note_q[target_q]   <= dec_note;
          active_q[target_q] <= 1'b1;
          start_q[target_q]  <= 1'b1;
          if (!retrig_q) freq_q[target_q] <= freq_val;
          // Move the written slot to most-recent; slots newer than it age by one.
          for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (rank_q[i] < rank_q[target_q]) rank_q[i] <= rank_q[i] + 1'b1;
          end
          rank_q[target_q] <= '0;
        end
        StRelease: begin
          for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (active_q[i] && note_q[i] == dec_note) active_q[i] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Flatten per-slot state onto the output buses.
  always_comb begin
    bus.div_num  = div_num_q;
    bus.div_den  = div_den_q;
    voice_active = '0;
    voice_start  = '0;
    voice_note   = '0;
    voice_freq   = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      voice_active[i]             = active_q[i];
      voice_start[i]              = start_q[i];
      voice_note[4*i +: 4]        = note_q[i];
      voice_freq[FREQ_W*i +: FREQ_W] = freq_q[i];
    end
  end

endmodule
